pipe_skid_latch: RTL and testbench
==================================

// Module: pipe_skid_latch
// PURPOSE
//  Parametrised elastic pipeline register: WIDTH-bit payload, valid/ready handshake on both sides,
//  plus a one-entry skid register. Its in_ready is registered, so there is no combinational path
//  from out_ready back to in_ready.
//  It replaces fixed en/flush stage latches between pipeline stages, e.g. EX/MEM and MEM/WB.
//  Sustains 1 transfer/cycle and absorbs a downstream stall without losing data.
// PARAMETERS
//  WIDTH       32  payload width in bits (a stage packs its fields into one word_t-style vector)
//  CLEAR_DATA  1   1: data registers are zeroed on flush and on pop-to-empty; 0: only valid bits cleared
// PORTS
//  CLK        in   1      clock, rising edge
//  nRST       in   1      asynchronous active-low reset
//  flush      in   1      synchronous squash of all held entries
//  in_valid   in   1      upstream holds a valid payload
//  in_ready   out  1      latch accepts a payload this cycle (registered)
//  in_data    in   WIDTH  upstream payload
//  out_valid  out  1      out_data is valid
//  out_ready  in   1      downstream consumes out_data this cycle
//  out_data   out  WIDTH  head payload (main register)
//  stall_cnt  out  32     present only with PIPE_SKID_LATCH_STATS_EN
// BEHAVIOUR
//  - Clock and reset: one clock, CLK. nRST is asynchronous and active-low. All outputs are registered.
//  - Reset values: state=EMPTY, out_valid=0, out_data=0, skid=0, in_ready=1, stall_cnt=0.
//  - Handshakes:
//    - in_fire  = in_valid & in_ready.
//    - out_fire = out_valid & out_ready.
//    - in_valid may be raised independent of in_ready.
//    - Upstream holds in_data stable until in_fire.
//  - States (skid_state_t): EMPTY (no entries), BUSY (main valid), FULL (main+skid valid).
//  - EMPTY:
//    - in_fire  -> main<=in_data; go to BUSY.
//    - no in_fire -> stay in EMPTY.
//  - BUSY:
//    - in_fire & out_fire  -> main<=in_data; stay in BUSY.
//    - in_fire & !out_fire -> skid<=in_data; go to FULL.
//    - !in_fire & out_fire -> go to EMPTY; clear main if CLEAR_DATA.
//    - neither -> hold.
//  - FULL (in_ready=0, so no in_fire):
//    - out_fire -> main<=skid; go to BUSY; clear skid if CLEAR_DATA.
//    - else hold.
//  - in_ready next = (next_state != FULL). out_valid next = (next_state != EMPTY).
//  - Latency: in_fire in cycle N -> out_valid in cycle N+1 when EMPTY/BUSY. Data order is strictly FIFO.
//  - Flush has highest priority:
//    - Next state is EMPTY; any in_fire in that cycle is discarded.
//    - Data is zeroed per CLEAR_DATA.
//    - in_ready=1 in the cycle after flush.
//  - A flush while FULL drops both entries. A flush while out_fire is high drops nothing extra:
//    the consumer already took the head.
//  - Reset mid-operation: asynchronously returns to the reset values, whatever the state or handshakes.
//  - Never more than 2 entries held. An entry is never overwritten without out_fire.
// CONFIGURATION
//  - PIPE_SKID_LATCH_STATS_EN defined:
//    - stall_cnt counts cycles with out_valid & !out_ready.
//    - It saturates at 32'hFFFF_FFFF (no wrap).
//    - It is cleared by nRST only, not by flush.
//  - Undefined: the stall_cnt port and counter logic are absent. Handshake behaviour is identical.
// STRUCTURE
//  - cpu_types_pkg gains typedef enum logic [1:0] {EMPTY, BUSY, FULL} skid_state_t.
//  - Stage payload structs (e.g. mem_wb payload) live in cpu_types_pkg and are passed as WIDTH=$bits(struct).
//  - One sub-module, sat_counter #(W=32): inc, value; async active-low reset. Used only under STATS_EN.
//  - Registers: state, main, skid, in_ready; one next-state always_comb block.
// TESTING
//  1. Reset, then in_valid=1, in_data=32'hA5A5_0001, out_ready=1.
//     -> out_valid=1 next cycle with 32'hA5A5_0001; in_ready stays 1.
//  2. Stream 0x10..0x1F with out_ready=1 every cycle.
//     -> 16 outputs in order, 1/cycle, 1-cycle latency, no bubbles.
//  3. BUSY with 0x20, out_ready=0, push 0x21.
//     -> FULL, in_ready=0. out_ready=1 -> 0x20, then 0x21; in_ready returns to 1.
//  4. FULL (0x30,0x31), assert flush and in_valid=1 with 0x32 together.
//     -> EMPTY next cycle, out_valid=0, out_data=0; 0x32 is never emitted.
//  5. Drop nRST while FULL.
//     -> out_valid=0, in_ready=1, out_data=0 immediately, with no clock edge needed.
//  6. STATS_EN: hold out_valid=1, out_ready=0 for 7 cycles.
//     -> stall_cnt=7. A flush leaves it at 7; nRST clears it to 0.

Source files
------------

// File: rtl/pipe_skid_latch_pkg.sv
// Shared types for the elastic pipeline latch: occupancy state of the main/skid register pair.
package pipe_skid_latch_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/pipe_skid_latch_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, cleared only by nRST.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         inc,
  output logic [W-1:0] value
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      value <= '0;
    end else if (inc && (value != {W{1'b1}})) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_skid_latch.sv
// Elastic pipeline register with one-entry skid buffer and registered in_ready.
// Optional stall statistics (stall_cnt port) when PIPE_SKID_LATCH_STATS_EN is defined.
module pipe_skid_latch
  import pipe_skid_latch_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_SKID_LATCH_STATS_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  skid_state_t      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q;
  logic             in_fire, out_fire;

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_d  = in_data;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          skid_d  = in_data;
          state_d = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
          if (CLEAR_DATA) main_d = '0;
        end
      end
      FULL: begin
        // in_ready is low here, so only the drain path exists.
        if (out_fire) begin
          main_d  = skid_q;
          state_d = BUSY;
          if (CLEAR_DATA) skid_d = '0;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Flush overrides everything, including a same-cycle in_fire.
    if (flush) begin
      state_d = EMPTY;
      if (CLEAR_DATA) begin
        main_d = '0;
        skid_d = '0;
      end else begin
        main_d = main_q;
        skid_d = skid_q;
      end
    end
  end

  // NOTE: payload registers are reset too, because out_data must read zero straight out of reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of its peers.
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != FULL);
    end
  end

`ifdef PIPE_SKID_LATCH_STATS_EN
  sat_counter #(.W(32)) u_stall_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (out_valid & ~out_ready),
    .value (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_skid_latch.sv
// Directed self-checking bench for pipe_skid_latch (WIDTH=32, CLEAR_DATA=1).
module tb_pipe_skid_latch;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
`ifdef PIPE_SKID_LATCH_STATS_EN
  logic [31:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  pipe_skid_latch #(.WIDTH(32), .CLEAR_DATA(1'b1)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_SKID_LATCH_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  // Advance one clock; outputs are sampled and inputs changed 1ns after the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    nRST = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) step();
    nRST = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++;
    if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_data = 32'hA5A5_0001; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hA5A5_0001)
      begin errors++; $display("FAIL single_out got v=%b d=%h want v=1 d=a5a50001", out_valid, out_data); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready got %b want 1", in_ready); end
    step();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0)
      begin errors++; $display("FAIL single_drain got v=%b d=%h want v=0 d=0", out_valid, out_data); end
  endtask

  task automatic test_stream();
    logic [31:0] exp;
    for (int i = 0; i < 16; i++) begin
      exp = 32'h10 + i;
      in_valid = 1'b1; in_data = exp; out_ready = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b1)
        begin errors++; $display("FAIL stream_%0d got v=%b d=%h r=%b want v=1 d=%h r=1", i, out_valid, out_data, in_ready, exp); end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_end got v=%b want 0", out_valid); end
  endtask

  task automatic test_skid();
    in_valid = 1'b1; in_data = 32'h20; out_ready = 1'b0;
    step();
    in_data = 32'h21;
    step();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h20)
      begin errors++; $display("FAIL skid_full got r=%b v=%b d=%h want r=0 v=1 d=20", in_ready, out_valid, out_data); end
    // Upstream offers 0x22 while full: must be refused, not overwrite anything.
    in_data = 32'h22;
    step();
    checks++;
    if (in_ready !== 1'b0 || out_data !== 32'h20)
      begin errors++; $display("FAIL skid_hold got r=%b d=%h want r=0 d=20", in_ready, out_data); end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h21 || in_ready !== 1'b1)
      begin errors++; $display("FAIL skid_drain1 got v=%b d=%h r=%b want v=1 d=21 r=1", out_valid, out_data, in_ready); end
    step();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0)
      begin errors++; $display("FAIL skid_drain2 got v=%b d=%h want v=0 d=0", out_valid, out_data); end
  endtask

  task automatic test_flush();
    in_valid = 1'b1; in_data = 32'h30; out_ready = 1'b0;
    step();
    in_data = 32'h31;
    step();
    flush = 1'b1; in_data = 32'h32;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL flush_full got v=%b d=%h r=%b want v=0 d=0 r=1", out_valid, out_data, in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_emit_%0d got v=%b d=%h want v=0", i, out_valid, out_data); end
    end
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; in_data = 32'h50; out_ready = 1'b0;
    step();
    in_data = 32'h51;
    step();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL areset_pre got r=%b want 0", in_ready); end
    #2 nRST = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0)
      begin errors++; $display("FAIL areset_now got v=%b r=%b d=%h want v=0 r=1 d=0", out_valid, in_ready, out_data); end
    #2 nRST = 1'b1;
    step();
  endtask

`ifdef PIPE_SKID_LATCH_STATS_EN
  task automatic test_stats();
    checks++;
    if (stall_cnt !== 32'd0) begin errors++; $display("FAIL stats_start got %0d want 0", stall_cnt); end
    in_valid = 1'b1; in_data = 32'h40; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    repeat (7) step();
    checks++;
    if (stall_cnt !== 32'd7) begin errors++; $display("FAIL stats_stall got %0d want 7", stall_cnt); end
    // Flush while the consumer takes the head: not a stall cycle, counter untouched.
    flush = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0;
    step();
    checks++;
    if (stall_cnt !== 32'd7) begin errors++; $display("FAIL stats_flush got %0d want 7", stall_cnt); end
    #2 nRST = 1'b0;
    #1;
    checks++;
    if (stall_cnt !== 32'd0) begin errors++; $display("FAIL stats_reset got %0d want 0", stall_cnt); end
    #2 nRST = 1'b1;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_skid();
    test_flush();
    test_async_reset();
`ifdef PIPE_SKID_LATCH_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
